// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: width codes, FSM states, owner codes
// and the helper that turns a width code into the index of the last byte.
package mem_port_arbiter_pkg;

  localparam logic [1:0] MEM_W_BYTE = 2'b00;
  localparam logic [1:0] MEM_W_HALF = 2'b01;
  localparam logic [1:0] MEM_W_WORD = 2'b10;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_TAIL = 2'd2;
  localparam logic [1:0] ARB_DONE = 2'd3;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Index of the final byte of an access (N-1); codes 10 and 11 are both a word.
  function automatic logic [1:0] last_idx(input logic [1:0] width);
    case (width)
      MEM_W_BYTE: last_idx = 2'd0;
      MEM_W_HALF: last_idx = 2'd1;
      default:    last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and MEM,
// serialising each granted request into byte accesses assembled little-endian.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_width_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i,
  output logic              rq_STALLER_o
);

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [1:0]        last;
  logic              owner;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [1:0]        cnt_prev;
  logic              busy;

  // Upper address bits beyond the RAM width are deliberately discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  assign cnt_prev = cnt - 2'd1;

  // NOTE: every register, including the rdata assembly word, is cleared by the async
  // reset so a transfer aborted by reset leaves no stale data or pending completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      cnt   <= 2'd0;
      last  <= 2'd0;
      owner <= OWN_IF;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= ZERO_WORD;
      rdata <= ZERO_WORD;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge value of cnt/state regardless of statement order.
      case (state)
        ARB_IDLE: begin
          if (mem_req_i) begin
            owner <= OWN_MEM;
            addr  <= mem_addr_i[ADDR_W-1:0];
            we    <= mem_we_i;
            wdata <= mem_wdata_i;
            last  <= last_idx(mem_width_i);
            rdata <= ZERO_WORD;
            cnt   <= 2'd0;
            state <= ARB_BUSY;
          end else if (if_req_i) begin
            owner <= OWN_IF;
            addr  <= if_addr_i[ADDR_W-1:0];
            we    <= 1'b0;
            wdata <= ZERO_WORD;
            last  <= last_idx(MEM_W_WORD);
            rdata <= ZERO_WORD;
            cnt   <= 2'd0;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // RAM data lags its address by one cycle, so this captures the previous byte.
          if (!we && cnt != 2'd0) begin
            rdata[{cnt_prev, 3'b000} +: 8] <= ram_din_i;
          end
          cnt <= cnt + 2'd1;
          if (cnt == last) begin
            state <= we ? ARB_DONE : ARB_TAIL;
          end
        end
        ARB_TAIL: begin
          rdata[{last, 3'b000} +: 8] <= ram_din_i;
          state <= ARB_DONE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state == ARB_BUSY);
  assign ram_addr_o = busy ? addr + ADDR_W'(cnt) : '0;
  assign ram_wr_o   = busy & we;
  assign ram_dout_o = busy ? wdata[{cnt, 3'b000} +: 8] : 8'h00;

  assign if_done_o   = (state == ARB_DONE) && (owner == OWN_IF);
  assign mem_done_o  = (state == ARB_DONE) && (owner == OWN_MEM);
  assign if_rdata_o  = rdata;
  assign mem_rdata_o = rdata;

  assign rq_STALLER_o = (mem_req_i & ~mem_done_o) | (if_req_i & ~if_done_o);

endmodule
